// File: rtl/shift_pkg.sv
// shift_pkg: mode encoding and default width shared by the shift/rotate unit
package shift_pkg;
  localparam int SHIFT_WIDTH = 8;
  localparam logic [2:0] SHIFT_SHL  = 3'd0;
  localparam logic [2:0] SHIFT_SHR  = 3'd1;
  localparam logic [2:0] SHIFT_RLC  = 3'd2;
  localparam logic [2:0] SHIFT_RRC  = 3'd3;
  localparam logic [2:0] SHIFT_ROL  = 3'd4;
  localparam logic [2:0] SHIFT_ROR  = 3'd5;
  localparam logic [2:0] SHIFT_ASR  = 3'd6;
  localparam logic [2:0] SHIFT_SWAP = 3'd7;
endpackage

// File: rtl/shift_core.sv
// shift_core: combinational shift/rotate operation table (in, cin, mode) -> (res, carry)
module shift_core import shift_pkg::*; #(
  parameter int WIDTH = SHIFT_WIDTH
) (
  input  logic [WIDTH-1:0] in,
  input  logic             cin,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] res,
  output logic             carry
);
  localparam int N = WIDTH - 1;
  localparam int H = WIDTH / 2;
  always_comb begin
    {carry, res} = '0;
    case (mode)
      SHIFT_SHL:  {carry, res} = {in[N], in[N-1:0], 1'b0};
      SHIFT_SHR:  {carry, res} = {in[0], 1'b0, in[N:1]};
      SHIFT_RLC:  {carry, res} = {in[N], in[N-1:0], cin};
      SHIFT_RRC:  {carry, res} = {in[0], cin, in[N:1]};
      SHIFT_ROL:  {carry, res} = {in[N], in[N-1:0], in[N]};
      SHIFT_ROR:  {carry, res} = {in[0], in[0], in[N:1]};
      SHIFT_ASR:  {carry, res} = {in[0], in[N], in[N:1]};
      SHIFT_SWAP: {carry, res} = {cin, in[H-1:0], in[N:H]};
      default:    {carry, res} = '0;
    endcase
  end
endmodule

// File: rtl/shift.sv
// shift: registered shift/rotate unit; zout flag present only with SHIFT_ZERO_FLAG_EN
module shift import shift_pkg::*; #(
  parameter int WIDTH = SHIFT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  input  logic             cin,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             cout
`ifdef SHIFT_ZERO_FLAG_EN
  ,
  output logic             zout
`endif
);
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic [WIDTH-1:0] r_out;
  logic             r_cout;
  shift_core #(.WIDTH(WIDTH)) u_core (
    .in    (in),
    .cin   (cin),
    .mode  (mode),
    .res   (w_res),
    .carry (w_carry)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {r_cout, r_out} <= '0;
    else if (en) {r_cout, r_out} <= {w_carry, w_res};
  assign out  = r_out;
  assign cout = r_cout;
`ifdef SHIFT_ZERO_FLAG_EN
  logic r_zout;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_zout <= 1'b0;
    else if (en) r_zout <= ~|w_res;
  assign zout = r_zout;
`endif
endmodule

// File: tb/tb_shift.sv
// tb_shift: directed literal checks plus randomized run against an arithmetic reference model
module tb_shift;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       cin = 1'b0;
  logic [7:0] in = 8'h00;
  logic [2:0] mode = 3'd0;
  logic [7:0] out;
  logic       cout;
  logic       zout;
  int checks = 0;
  int errors = 0;
  logic       chk_en = 1'b0;
  logic [7:0] m_out = 8'h00;
  logic       m_cout = 1'b0;
  logic       m_zout = 1'b0;

  shift #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .in    (in),
    .cin   (cin),
    .mode  (mode),
    .out   (out),
    .cout  (cout)
`ifdef SHIFT_ZERO_FLAG_EN
    ,
    .zout  (zout)
`endif
  );
`ifndef SHIFT_ZERO_FLAG_EN
  assign zout = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference operation expressed as integer arithmetic on an 8-bit value
  function automatic logic [8:0] ref_op(input int a, input int c, input int m);
    int o, co;
    case (m)
      0: begin o = (a * 2) % 256;                co = a / 128; end
      1: begin o = a / 2;                        co = a % 2;   end
      2: begin o = (a * 2) % 256 + c;            co = a / 128; end
      3: begin o = a / 2 + c * 128;              co = a % 2;   end
      4: begin o = (a * 2) % 256 + a / 128;      co = a / 128; end
      5: begin o = a / 2 + (a % 2) * 128;        co = a % 2;   end
      6: begin o = a / 2 + (a / 128) * 128;      co = a % 2;   end
      default: begin o = (a % 16) * 16 + a / 16; co = c;       end
    endcase
    return {co[0], o[7:0]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [8:0] r;
    if (!rst_n) begin
      m_out <= 8'h00; m_cout <= 1'b0; m_zout <= 1'b0;
    end else if (en) begin
      r = ref_op(int'(in), int'(cin), int'(mode));
      m_out <= r[7:0]; m_cout <= r[8]; m_zout <= (r[7:0] == 8'h00);
    end
  end

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("model", {1'b0, cout, out}, {1'b0, m_cout, m_out});
`ifdef SHIFT_ZERO_FLAG_EN
    check("model_z", {9'd0, zout}, {9'd0, m_zout});
`endif
  end

  task automatic apply(input logic [7:0] a, input logic c, input logic [2:0] m);
    in = a; cin = c; mode = m; en = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [8:0] sweep [8] = '{9'h154, 9'h055, 9'h054 | 9'h100, 9'h055,
                            9'h155, 9'h055, 9'h0D5, 9'h0AA};

  initial begin
    in = 8'hAA; en = 1'b1;
    #1 rst_n = 1'b0;
    #2 check("reset", {1'b0, cout, out}, 10'h000);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    for (int m = 0; m < 8; m++) begin
      apply(8'hAA, 1'b0, 3'(m));
      check($sformatf("sweep%0d", m), {1'b0, cout, out}, {1'b0, sweep[m]});
    end
    apply(8'hAA, 1'b1, 3'd2); check("rlc_c1",  {1'b0, cout, out}, 10'h155);
    apply(8'hAA, 1'b1, 3'd3); check("rrc_c1",  {1'b0, cout, out}, 10'h0D5);
    apply(8'hAA, 1'b1, 3'd7); check("swap_c1", {1'b0, cout, out}, 10'h1AA);
    apply(8'h81, 1'b0, 3'd4); check("hold_ld", {1'b0, cout, out}, 10'h103);
    en = 1'b0; in = 8'h00;
    repeat (3) @(posedge clk);
    #1 check("hold", {1'b0, cout, out}, 10'h103);
    apply(8'hAA, 1'b0, 3'd0); check("lat0", {1'b0, cout, out}, 10'h154);
    mode = 3'd1;
    #3 check("lat_wait", {1'b0, cout, out}, 10'h154);
    @(posedge clk); #1 check("lat1", {1'b0, cout, out}, 10'h055);
`ifdef SHIFT_ZERO_FLAG_EN
    apply(8'h01, 1'b0, 3'd1);
    check("zero_hit", {zout, cout, out}, 10'h300);
    apply(8'h80, 1'b0, 3'd6);
    check("zero_miss", {zout, cout, out}, 10'h0C0);
`endif
    apply(8'hFF, 1'b1, 3'd4);
    rst_n = 1'b0;
    #1 check("async_rst", {zout, cout, out}, 10'h000);
    repeat (2) @(posedge clk);
    #1 check("rst_hold", {zout, cout, out}, 10'h000);
    in = 8'h3C; cin = 1'b0; mode = 3'd7;
    rst_n = 1'b1;
    @(posedge clk); #1 check("rst_first", {zout, cout, out}, 10'h0C3);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      in = 8'($urandom); cin = 1'($urandom); mode = 3'($urandom);
      en = ($urandom_range(0, 9) < 8);
      rst_n = ($urandom_range(0, 49) != 0);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
